// File: rtl/uart_tx_controller.sv
// uart_tx_controller
//   Transmit sequencer for a UART. Accepts one byte per start/ready handshake
//   and shifts it out on tx as: start bit, 8 data bits LSB first, optional
//   parity bit, stop bit(s). Parity is formed from the byte captured at
//   acceptance, so later changes on dat/parity inputs never disturb a frame.
//
//   Build option: define UART_TX_TWO_STOP_EN for two stop bits (default one).
//
//   Ports
//     clk          system clock, rising edge
//     reset        synchronous, active-high reset
//     dat[7:0]     byte to send, captured on acceptance
//     start        transmit request, accepted when start && ready
//     parity_en    1 = append parity bit (captured on acceptance)
//     parity_even  1 = even parity, 0 = odd (captured on acceptance)
//     ready        high while idle (state == IDLE)
//     tx           registered serial output, idles high
//     done         one-cycle pulse during the last cycle of the final stop bit
//
//   Back-to-back: when start is high during the done cycle the next byte is
//   captured at that same edge and the FSM goes straight to START, so the
//   following start bit directly abuts the stop bit with no idle gap.
module uart_tx_controller #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dat,
  input  logic       start,
  input  logic       parity_en,
  input  logic       parity_even,
  output logic       ready,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [2:0]       bit_idx_inc;
  logic             tx_nxt;
  logic             load;
  logic             bit_end;
  logic             last_stop;
  logic             parity_bit;

  // Frame contents captured at acceptance; control-only reset.
  logic [7:0]       data_q;
  logic             par_en_q;
  logic             par_even_q;

`ifdef UART_TX_TWO_STOP_EN
  logic             stop_q, stop_nxt;
  assign last_stop = stop_q;
`else
  assign last_stop = 1'b1;
`endif

  assign bit_end     = (cnt == CNT_MAX);
  assign bit_idx_inc = bit_idx + 3'd1;
  // Even parity is the plain XOR; odd parity inverts it.
  assign parity_bit  = (^data_q) ^ ~par_even_q;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    tx_nxt      = tx;
    load        = 1'b0;
    done        = 1'b0;
    ready       = (state == IDLE);
`ifdef UART_TX_TWO_STOP_EN
    stop_nxt    = stop_q;
`endif

    if (state != IDLE) begin
      cnt_nxt = bit_end ? '0 : cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = START;
          cnt_nxt   = '0;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            if (par_en_q) begin
              state_nxt = PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
              stop_nxt  = 1'b0;
`endif
            end
          end else begin
            bit_idx_nxt = bit_idx_inc;
            tx_nxt      = data_q[bit_idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
          stop_nxt  = 1'b0;
`endif
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            done = 1'b1;
            // Chain the next frame directly when a request is waiting.
            if (start) begin
              load      = 1'b1;
              state_nxt = START;
              tx_nxt    = 1'b0;
            end else begin
              state_nxt = IDLE;
              tx_nxt    = 1'b1;
            end
          end
`ifdef UART_TX_TWO_STOP_EN
          else begin
            stop_nxt = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
`ifdef UART_TX_TWO_STOP_EN
      stop_q  <= stop_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data_q     <= dat;
      par_en_q   <= parity_en;
      par_even_q <= parity_even;
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Testbench for uart_tx_controller with CLK_PER_BIT = 4.
// Stimulus pushes the expected frame (bit string, start-bit first) into a
// queue; a monitor decodes tx mid-bit, and on each done pulse pops and
// compares bits, done timing, ready behaviour and inter-frame gap.
module tb_uart_tx_controller;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dat;
  logic       start;
  logic       parity_en;
  logic       parity_even;
  logic       ready;
  logic       tx;
  logic       done;

  uart_tx_controller #(.CLK_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .dat        (dat),
    .start      (start),
    .parity_en  (parity_en),
    .parity_even(parity_even),
    .ready      (ready),
    .tx         (tx),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    string bits;
    int    gap;
    bit    chk_ready;
  } exp_t;

  exp_t  q[$];
  exp_t  e;
  int    n_chk = 0;
  int    n_fail = 0;
  string stop_tail;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic check_s(input string nm, input string act, input string req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", nm, act, req);
    end
  endtask

  // Monitor / scoreboard
  bit    in_frame = 1'b0;
  bit    pend_ready = 1'b0;
  int    fc = 0;
  int    cyc = 0;
  int    last_done = -1000;
  int    gap_meas = 0;
  int    ready_hi = 0;
  string got;
  string cur_name;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_frame   = 1'b0;
      pend_ready = 1'b0;
    end else begin
      if (pend_ready) begin
        check({cur_name, " ready after done"}, int'(ready), 1);
        pend_ready = 1'b0;
      end
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        fc       = 0;
        got      = "";
        ready_hi = 0;
        gap_meas = cyc - last_done - 1;
      end
      if (in_frame) begin
        fc++;
        if (ready) ready_hi++;
        if ((fc - 1) % CPB == 1) got = {got, (tx ? "1" : "0")};
        if (fc > 100) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame timeout: got %0d cycles without done, expected at most 48", fc);
          in_frame = 1'b0;
        end
      end
      if (done) begin
        if (!in_frame || q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected done: got pulse at cycle %0d, expected none (queued=%0d)", cyc, q.size());
          in_frame = 1'b0;
        end else begin
          e = q.pop_front();
          check_s({e.name, " bits"}, got, e.bits);
          check({e.name, " done cycle"}, fc, e.bits.len() * CPB);
          check({e.name, " ready high in frame"}, ready_hi, 0);
          if (e.gap >= 0) check({e.name, " idle gap"}, gap_meas, e.gap);
          pend_ready = e.chk_ready;
          cur_name   = e.name;
          in_frame   = 1'b0;
          last_done  = cyc;
        end
      end
    end
  end

  task automatic push(input string nm, input string bits, input int gap, input bit chk_rdy);
    exp_t x;
    x.name      = nm;
    x.bits      = bits;
    x.gap       = gap;
    x.chk_ready = chk_rdy;
    q.push_back(x);
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s wait ready: got ready=0 after %0d cycles, expected 1", nm, t);
    end
  endtask

  task automatic send(input string nm, input logic [7:0] d, input logic pe, input logic pev,
                      input string bits, input bit chk_rdy);
    wait_ready(nm);
    if (bits.len() > 0) push(nm, bits, -1, chk_rdy);
    dat         = d;
    parity_en   = pe;
    parity_even = pev;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while ((q.size() != 0 || in_frame) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || in_frame) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s drain: got %0d frames pending, expected 0", nm, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
`ifdef UART_TX_TWO_STOP_EN
    stop_tail = "11";
`else
    stop_tail = "1";
`endif
    reset       = 1'b1;
    start       = 1'b0;
    dat         = 8'h00;
    parity_en   = 1'b0;
    parity_even = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset tx", int'(tx), 1);
    check("reset ready", int'(ready), 1);
    check("reset done", int'(done), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // A5 = 1010_0101 -> LSB first 10100101, popcount 4
    send("even A5", 8'hA5, 1'b1, 1'b1, {"0", "10100101", "0", stop_tail}, 1'b1);
    wait_idle("even A5");
    send("odd A5", 8'hA5, 1'b1, 1'b0, {"0", "10100101", "1", stop_tail}, 1'b1);
    wait_idle("odd A5");
    send("nopar A5", 8'hA5, 1'b0, 1'b1, {"0", "10100101", stop_tail}, 1'b1);
    wait_idle("nopar A5");

    // Back-to-back: start held high across the first frame's done cycle
    wait_ready("b2b");
    push("b2b 00", {"0", "00000000", stop_tail}, -1, 1'b0);
    push("b2b FF", {"0", "11111111", stop_tail}, 0, 1'b1);
    dat       = 8'h00;
    parity_en = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    t = 0;
    @(negedge clk);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    dat = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("b2b");

    // Busy: request at cycle 10 with altered inputs must be ignored
    send("busy 5A", 8'h5A, 1'b0, 1'b0, {"0", "01011010", stop_tail}, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    start       = 1'b1;
    dat         = 8'hFF;
    parity_en   = 1'b1;
    parity_even = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("busy 5A");
    repeat (10) @(negedge clk);
    check("busy no second frame", int'(in_frame), 0);

    // Reset during DATA bit 3 aborts the frame without done
    send("abort C3", 8'hC3, 1'b0, 1'b0, "", 1'b0);
    repeat (17) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort tx idle", int'(tx), 1);
    check("abort ready", int'(ready), 1);
    repeat (3) @(negedge clk);
    // 3C = 0011_1100 -> LSB first 00111100, popcount 4
    send("after reset 3C", 8'h3C, 1'b1, 1'b1, {"0", "00111100", "0", stop_tail}, 1'b1);
    wait_idle("after reset 3C");

    check("queue empty at end", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
